// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC SPI responder: command codes,
// per-command payload lengths, register-file layout and reset values,
// plus small helpers for register addressing and BCD counting.
package rtc_pkg;

  typedef enum logic [2:0] {
    CMD_RESET    = 3'd0,
    CMD_STATUS   = 3'd1,
    CMD_DATETIME = 3'd2,
    CMD_TIME     = 3'd3,
    CMD_ALARM    = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_IGNORE
  } state_e;

  // Upper nibble every valid command byte must carry.
  localparam logic [3:0] SYNC_MARKER       = 4'hF;
  localparam logic [2:0] CMD_FIRST_INVALID = 3'd5;

  // Payload bytes per command index.
  localparam logic [3:0] CMD_LEN [8] = '{4'd0, 4'd1, 4'd7, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0};

  // Register file layout (status lives outside the array).
  localparam int         NUM_REGS     = 9;
  localparam logic [3:0] REG_YEAR     = 4'd0;
  localparam logic [3:0] REG_MON      = 4'd1;
  localparam logic [3:0] REG_DAY      = 4'd2;
  localparam logic [3:0] REG_WDAY     = 4'd3;
  localparam logic [3:0] REG_HOUR     = 4'd4;
  localparam logic [3:0] REG_MIN      = 4'd5;
  localparam logic [3:0] REG_SEC      = 4'd6;
  localparam logic [3:0] REG_ALARM_HH = 4'd7;
  localparam logic [3:0] REG_ALARM_MM = 4'd8;

  localparam logic [7:0] RST_YEAR   = 8'h00;
  localparam logic [7:0] RST_MON    = 8'h01;
  localparam logic [7:0] RST_DAY    = 8'h01;
  localparam logic [7:0] RST_WDAY   = 8'h00;
  localparam logic [7:0] RST_TIME   = 8'h00;
  localparam logic [7:0] RST_ALARM  = 8'h00;
  localparam logic [7:0] RST_STATUS = 8'h00;

  // First register a multi-byte command addresses.
  function automatic logic [3:0] reg_base(input logic [2:0] c);
    case (cmd_e'(c))
      CMD_DATETIME: reg_base = REG_YEAR;
      CMD_TIME:     reg_base = REG_HOUR;
      CMD_ALARM:    reg_base = REG_ALARM_HH;
      default:      reg_base = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] reg_reset_val(input logic [3:0] r);
    case (r)
      REG_YEAR:                   reg_reset_val = RST_YEAR;
      REG_MON:                    reg_reset_val = RST_MON;
      REG_DAY:                    reg_reset_val = RST_DAY;
      REG_WDAY:                   reg_reset_val = RST_WDAY;
      REG_HOUR, REG_MIN, REG_SEC: reg_reset_val = RST_TIME;
      REG_ALARM_HH, REG_ALARM_MM: reg_reset_val = RST_ALARM;
      default:                    reg_reset_val = 8'h00;
    endcase
  endfunction

  // Plain BCD increment; wrap points are handled by the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/rtc_spi_target_shift.sv
// SPI target front end: input synchronizers, SPIClk edge detection, 8-bit
// receive/transmit shifters, byte-done pulse and select/deselect pulses.
// A byte is done one cycle after its 8th synced rising edge.
module rtc_spi_target_shift
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_nsel_i,
  input  logic       spi_di_i,
  input  logic       load_i,
  input  logic [7:0] load_byte_i,
  output logic       sel_fall_o,
  output logic       desel_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic       tx_msb_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q, nsel_sync_q, di_sync_q;
  logic                   clk_prev_q, nsel_prev_q;
  logic                   clk_s, nsel_s, di_s, rise, fall;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             rx_q, rx_d, tx_q, tx_d;
  logic                   done_q, done_d;

  // Synchronizers and edge history; history follows the synced level even in
  // reset so releasing reset with the target selected never fakes an edge.
  always_ff @(posedge clk_i) begin
    clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    nsel_sync_q <= {nsel_sync_q[SYNC_STAGES-2:0], spi_nsel_i};
    di_sync_q   <= {di_sync_q[SYNC_STAGES-2:0], spi_di_i};
    clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    nsel_prev_q <= nsel_sync_q[SYNC_STAGES-1];
  end

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign nsel_s     = nsel_sync_q[SYNC_STAGES-1];
  assign di_s       = di_sync_q[SYNC_STAGES-1];
  assign rise       = clk_s & ~clk_prev_q & ~nsel_s;
  assign fall       = ~clk_s & clk_prev_q & ~nsel_s;
  assign sel_fall_o = ~nsel_s & nsel_prev_q;
  assign desel_o    = nsel_s & ~nsel_prev_q;

  // Shift in on rising edges, shift out on falling edges; the falling edge
  // right after a byte boundary is skipped so a freshly loaded MSB stays put.
  always_comb begin
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    done_d = 1'b0;
    if (sel_fall_o || desel_o) begin
      cnt_d = 3'd0;
    end else if (rise) begin
      rx_d   = {rx_q[6:0], di_s};
      cnt_d  = cnt_q + 3'd1;
      done_d = (cnt_q == 3'd7);
    end
    if (load_i)                    tx_d = load_byte_i;
    else if (fall && cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
  end

  // Shifter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 3'd0;
      rx_q   <= 8'h00;
      tx_q   <= 8'h00;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      done_q <= done_d;
    end
  end

  assign byte_done_o = done_q;
  assign rx_byte_o   = rx_q;
  assign tx_msb_o    = tx_q[7];

endmodule

// File: rtl/rtc_spi_responder.sv
// RTC-side SPI target: decodes a command byte, then streams register bytes
// out (read) or commits received bytes (write); deselect aborts at any time.
// Optional 1 Hz BCD time keeping is enabled by defining RTC_RESPONDER_TICK_EN.
module rtc_spi_responder
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic       SPIClk,
  input  logic       nSPISel,
  input  logic       SPIDi,
  output logic       SPIDo,
  output logic       SPIDoEn,
  output logic       CmdStrobe,
  output logic [2:0] CmdIndex,
  output logic [7:0] Status
`ifdef RTC_RESPONDER_TICK_EN
  ,
  input  logic       TickSec,
  output logic       DayCarry
`endif
);

  state_e     state_q, state_d;
  logic [2:0] cmd_q, cmd_d, idx_q, idx_d, cmd_index_q, cmd_index_d;
  logic       wr_q, wr_d, strobe_q, strobe_d;
  logic [7:0] status_q, status_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       sel_fall, desel, byte_done, tx_msb, load, commit;
  logic [7:0] rx_byte, rd_val;
  logic [2:0] rd_cmd, rd_idx;
  logic [3:0] rd_addr, wr_addr;

`ifdef RTC_RESPONDER_TICK_EN
  logic tick_pend_q, tick_pend_d, day_carry_q, day_carry_d;
`endif

  rtc_spi_target_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk_i       (SClk),
    .rst_i       (Reset),
    .spi_clk_i   (SPIClk),
    .spi_nsel_i  (nSPISel),
    .spi_di_i    (SPIDi),
    .load_i      (load),
    .load_byte_i (rd_val),
    .sel_fall_o  (sel_fall),
    .desel_o     (desel),
    .byte_done_o (byte_done),
    .rx_byte_o   (rx_byte),
    .tx_msb_o    (tx_msb)
  );

  // Next byte to present: byte 0 of a just-decoded command, else the one after idx_q.
  always_comb begin
    rd_cmd = cmd_q;
    rd_idx = idx_q + 3'd1;
    if (state_q == ST_CMD) begin
      rd_cmd = rx_byte[3:1];
      rd_idx = 3'd0;
    end
    rd_addr = reg_base(rd_cmd) + {1'b0, rd_idx};
    rd_val  = (rd_cmd == CMD_STATUS) ? status_q : regs_q[rd_addr];
    wr_addr = reg_base(cmd_q) + {1'b0, idx_q};
  end

  // Command FSM, register-file writes and optional time keeping.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    status_d    = status_q;
    regs_d      = regs_q;
    strobe_d    = 1'b0;
    cmd_index_d = cmd_index_q;
    load        = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_fall) state_d = ST_CMD;
      ST_CMD: if (byte_done) begin
        if (rx_byte[7:4] != SYNC_MARKER || rx_byte[3:1] >= CMD_FIRST_INVALID) begin
          state_d = ST_IGNORE;
        end else if (rx_byte[3:1] == CMD_RESET) begin
          status_d = RST_STATUS;
          for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_reset_val(4'(i));
          commit      = 1'b1;
          strobe_d    = 1'b1;
          cmd_index_d = CMD_RESET;
          state_d     = ST_IGNORE;
        end else begin
          cmd_d   = rx_byte[3:1];
          wr_d    = rx_byte[0];
          idx_d   = 3'd0;
          load    = ~rx_byte[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (byte_done) begin
        if (wr_q) begin
          commit = 1'b1;
          if (cmd_q == CMD_STATUS) status_d = rx_byte;
          else                     regs_d[wr_addr] = rx_byte;
        end
        if ({1'b0, idx_q} + 4'd1 == CMD_LEN[cmd_q]) begin
          strobe_d    = 1'b1;
          cmd_index_d = cmd_q;
          state_d     = ST_IGNORE;
        end else begin
          idx_d = idx_q + 3'd1;
          load  = ~wr_q;
        end
      end
      default: ;
    endcase
    if (desel) state_d = ST_IDLE;

`ifdef RTC_RESPONDER_TICK_EN
    // A tick that lands on a register commit waits one cycle.
    tick_pend_d = 1'b0;
    day_carry_d = 1'b0;
    if (TickSec || tick_pend_q) begin
      if (commit) begin
        tick_pend_d = 1'b1;
      end else if (regs_q[REG_SEC] != 8'h59) begin
        regs_d[REG_SEC] = bcd_inc(regs_q[REG_SEC]);
      end else begin
        regs_d[REG_SEC] = 8'h00;
        if (regs_q[REG_MIN] != 8'h59) begin
          regs_d[REG_MIN] = bcd_inc(regs_q[REG_MIN]);
        end else begin
          regs_d[REG_MIN] = 8'h00;
          if (regs_q[REG_HOUR] != 8'h23) begin
            regs_d[REG_HOUR] = bcd_inc(regs_q[REG_HOUR]);
          end else begin
            regs_d[REG_HOUR] = 8'h00;
            day_carry_d      = 1'b1;
          end
        end
      end
    end
`endif
  end

  // State and register file.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 3'd0;
      idx_q       <= 3'd0;
      wr_q        <= 1'b0;
      status_q    <= RST_STATUS;
      strobe_q    <= 1'b0;
      cmd_index_q <= 3'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_reset_val(4'(i));
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      status_q    <= status_d;
      strobe_q    <= strobe_d;
      cmd_index_q <= cmd_index_d;
      regs_q      <= regs_d;
    end
  end

`ifdef RTC_RESPONDER_TICK_EN
  // Pending tick and day-carry pulse.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      tick_pend_q <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      tick_pend_q <= tick_pend_d;
      day_carry_q <= day_carry_d;
    end
  end

  assign DayCarry = day_carry_q;
`endif

  // Drive zeros during the command byte, data on reads, ones once ignoring.
  always_comb begin
    case (state_q)
      ST_DATA:   SPIDo = tx_msb & ~wr_q;
      ST_IGNORE: SPIDo = 1'b1;
      default:   SPIDo = 1'b0;
    endcase
  end

  assign SPIDoEn   = (state_q != ST_IDLE);
  assign CmdStrobe = strobe_q;
  assign CmdIndex  = cmd_index_q;
  assign Status    = status_q;

endmodule
